// File: rtl/ams_pwm_dac_if.sv
// Setpoint and PWM output bundle between the AMS register block and one slow-DAC PWM channel.
`timescale 1ns/1ps
interface ams_pwm_dac_if;
    logic        en_i;
    logic [23:0] cfg_i;
    logic        pwm_o;
    logic        frame_o;

    modport master (
        output en_i,
        output cfg_i,
        input  pwm_o,
        input  frame_o
    );

    modport slave (
        input  en_i,
        input  cfg_i,
        output pwm_o,
        output frame_o
    );
endinterface

// File: rtl/ams_pwm_dac.sv
// Dithered PWM DAC: 8-bit base duty plus a 16-bit per-period dither mask, reloaded only at frame end.
`timescale 1ns/1ps
module ams_pwm_dac #(
    parameter int unsigned FULL = 156
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    ams_pwm_dac_if.slave  bus
);

    localparam int unsigned VW    = 8;
    localparam int unsigned BW    = 4;
    localparam int unsigned CW    = 24;
    localparam int unsigned TW    = VW + 1;
    localparam logic [VW-1:0] LAST = VW'(FULL - 1);

    logic [VW-1:0] vcnt_q,   vcnt_d;
    logic [BW-1:0] bcnt_q,   bcnt_d;
    logic [CW-1:0] shadow_q, shadow_d;
    logic          pwm_q,    pwm_d;
    logic          frame_q,  frame_d;

    logic [15:0]   dmask_c;
    logic [TW-1:0] thr_c;
    logic          wrap_c;
    logic          frame_end_c;

    // Threshold for the current period; 9 bits so V=255 plus a dither bit cannot overflow.
    assign dmask_c     = shadow_q[15:0];
    assign thr_c       = {1'b0, shadow_q[23:16]} + TW'(dmask_c[bcnt_q]);
    assign wrap_c      = (vcnt_q == LAST);
    assign frame_end_c = wrap_c && (bcnt_q == BW'(15));

    always_comb begin
        vcnt_d   = vcnt_q;
        bcnt_d   = bcnt_q;
        shadow_d = shadow_q;
        pwm_d    = 1'b0;
        frame_d  = 1'b0;

        if (!bus.en_i) begin
            // Disabled: park counters and keep tracking the setpoint so enabling starts fresh.
            vcnt_d   = '0;
            bcnt_d   = '0;
            shadow_d = bus.cfg_i;
        end else begin
            pwm_d  = ({1'b0, vcnt_q} < thr_c);
            vcnt_d = wrap_c ? '0 : vcnt_q + VW'(1);
            if (wrap_c) begin
                bcnt_d = bcnt_q + BW'(1);
            end
            if (frame_end_c) begin
                shadow_d = bus.cfg_i;
                frame_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vcnt_q   <= '0;
            bcnt_q   <= '0;
            shadow_q <= '0;
            pwm_q    <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            vcnt_q   <= vcnt_d;
            bcnt_q   <= bcnt_d;
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.pwm_o   = pwm_q;
    assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_ams_pwm_dac.sv
// Bench for ams_pwm_dac: per-clock scoreboard plus per-period duty measurements.
`timescale 1ns/1ps
module tb_ams_pwm_dac;

    localparam int unsigned FULL  = 156;
    localparam int unsigned FRAME = FULL * 16;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    ams_pwm_dac_if bus ();

    ams_pwm_dac #(.FULL(FULL)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Scoreboard: expected {pwm, frame} pushed at each active edge, popped on the following falling edge.
    logic [1:0]  q[$];
    int          m_v;
    int          m_b;
    logic [23:0] m_sh;
    int          m_thr;
    logic        m_fe;
    logic [1:0]  e_pop;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_v  = 0;
            m_b  = 0;
            m_sh = '0;
            q.delete();
        end else if (bus.en_i !== 1'b1) begin
            q.push_back(2'b00);
            m_v  = 0;
            m_b  = 0;
            m_sh = bus.cfg_i;
        end else begin
            m_thr = int'(m_sh[23:16]) + int'(m_sh[m_b]);
            m_fe  = (m_v == FULL - 1) && (m_b == 15);
            q.push_back({(m_v < m_thr), m_fe});
            if (m_fe) m_sh = bus.cfg_i;
            if (m_v == FULL - 1) begin
                m_v = 0;
                m_b = (m_b + 1) % 16;
            end else begin
                m_v = m_v + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn === 1'b1 && q.size() > 0) begin
            e_pop = q.pop_front();
            total++;
            if ({bus.pwm_o, bus.frame_o} !== e_pop) begin
                bad++;
                $display("FAIL sb_cycle t=%0t got pwm=%b frame=%b want pwm=%b frame=%b",
                         $time, bus.pwm_o, bus.frame_o, e_pop[1], e_pop[0]);
            end
        end
    end

    // Per-period measurement results.
    int   per_hi[16];
    int   frm_cnt;
    int   frm_idx;
    int   mono_err;
    int   hi_sum;
    logic prev;

    // Samples nsamp clocks starting at a falling edge; optionally changes cfg_i before sample chg_i.
    task automatic measure(input int nsamp, input int chg_i, input logic [23:0] chg_cfg);
        for (int k = 0; k < 16; k++) per_hi[k] = 0;
        frm_cnt  = 0;
        frm_idx  = -1;
        mono_err = 0;
        hi_sum   = 0;
        prev     = 1'b0;
        for (int i = 0; i < nsamp; i++) begin
            if (i == chg_i) bus.cfg_i = chg_cfg;
            @(negedge clk);
            if (bus.pwm_o === 1'b1) begin
                per_hi[(i / FULL) % 16]++;
                hi_sum++;
            end
            if ((i % FULL) != 0 && bus.pwm_o === 1'b1 && prev === 1'b0) mono_err++;
            prev = bus.pwm_o;
            if (bus.frame_o === 1'b1) begin
                frm_cnt++;
                frm_idx = i;
            end
        end
    endtask

    task automatic test_reset();
        rstn       = 1'b0;
        bus.en_i   = 1'b0;
        bus.cfg_i  = 24'h000000;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.pwm_o, bus.frame_o} !== 2'b00) begin
            bad++;
            $display("FAIL reset_state got pwm=%b frame=%b want 0 0", bus.pwm_o, bus.frame_o);
        end
        rstn      = 1'b1;
        bus.cfg_i = 24'h4E0000;
        @(negedge clk);
        bus.en_i = 1'b1;
        total++;
        if (bus.pwm_o !== 1'b0) begin
            bad++;
            $display("FAIL pre_enable got pwm=%b want 0", bus.pwm_o);
        end
        @(negedge clk);
        total++;
        if (bus.pwm_o !== 1'b1) begin
            bad++;
            $display("FAIL first_rise got pwm=%b want 1", bus.pwm_o);
        end
        repeat (20) @(negedge clk);
        total++;
        if (bus.pwm_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_period_high got pwm=%b want 1", bus.pwm_o);
        end
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({bus.pwm_o, bus.frame_o} !== 2'b00) begin
            bad++;
            $display("FAIL async_reset got pwm=%b frame=%b want 0 0", bus.pwm_o, bus.frame_o);
        end
        @(negedge clk);
        rstn     = 1'b1;
        bus.en_i = 1'b0;
        @(negedge clk);
        bus.en_i = 1'b1;
    endtask

    task automatic test_half_duty();
        for (int f = 0; f < 2; f++) begin
            measure(FRAME, -1, 24'h0);
            for (int k = 0; k < 16; k++) begin
                total++;
                if (per_hi[k] !== 78) begin
                    bad++;
                    $display("FAIL half_duty f=%0d period=%0d got high=%0d want 78", f, k, per_hi[k]);
                end
            end
            total++;
            if (mono_err !== 0) begin
                bad++;
                $display("FAIL half_shape f=%0d got late_rises=%0d want 0", f, mono_err);
            end
            total++;
            if (frm_cnt !== 1 || frm_idx !== FRAME - 1) begin
                bad++;
                $display("FAIL frame_interval f=%0d got count=%0d idx=%0d want 1 %0d",
                         f, frm_cnt, frm_idx, FRAME - 1);
            end
        end
    endtask

    task automatic test_dither();
        measure(FRAME, 0, 24'h100001);
        measure(FRAME, -1, 24'h0);
        for (int k = 0; k < 16; k++) begin
            total++;
            if (per_hi[k] !== ((k == 0) ? 17 : 16)) begin
                bad++;
                $display("FAIL dither period=%0d got high=%0d want %0d", k, per_hi[k], (k == 0) ? 17 : 16);
            end
        end
        total++;
        if (hi_sum !== 257) begin
            bad++;
            $display("FAIL dither_total got %0d want 257", hi_sum);
        end
    endtask

    task automatic test_saturation();
        logic [23:0] cfgs[3];
        int          want[3];
        cfgs[0] = 24'hFFFFFF; want[0] = FRAME;
        cfgs[1] = 24'h9BFFFF; want[1] = FRAME;
        cfgs[2] = 24'h000000; want[2] = 0;
        for (int c = 0; c < 3; c++) begin
            measure(FRAME, 0, cfgs[c]);
            measure(FRAME, -1, 24'h0);
            total++;
            if (hi_sum !== want[c]) begin
                bad++;
                $display("FAIL saturation cfg=%06h got high=%0d want %0d", cfgs[c], hi_sum, want[c]);
            end
        end
    endtask

    task automatic test_setpoint();
        measure(FRAME, 0, 24'h4E0000);
        measure(FRAME, 5 * FULL + 10, 24'h0F0000);
        for (int k = 0; k < 16; k++) begin
            total++;
            if (per_hi[k] !== 78) begin
                bad++;
                $display("FAIL no_tearing period=%0d got high=%0d want 78", k, per_hi[k]);
            end
        end
        total++;
        if (frm_cnt !== 1 || frm_idx !== FRAME - 1) begin
            bad++;
            $display("FAIL switch_frame got count=%0d idx=%0d want 1 %0d", frm_cnt, frm_idx, FRAME - 1);
        end
        measure(FRAME, -1, 24'h0);
        for (int k = 0; k < 16; k++) begin
            total++;
            if (per_hi[k] !== 15) begin
                bad++;
                $display("FAIL new_setpoint period=%0d got high=%0d want 15", k, per_hi[k]);
            end
        end
    endtask

    task automatic test_frame_edge();
        measure(FRAME, FRAME - 1, 24'h200000);
        total++;
        if (hi_sum !== 15 * 16) begin
            bad++;
            $display("FAIL edge_old_frame got high=%0d want %0d", hi_sum, 15 * 16);
        end
        measure(FRAME, -1, 24'h0);
        total++;
        if (hi_sum !== 32 * 16) begin
            bad++;
            $display("FAIL edge_capture got high=%0d want %0d", hi_sum, 32 * 16);
        end
    endtask

    task automatic test_enable();
        int nz;
        measure(5 * FULL + 30, -1, 24'h0);
        bus.en_i  = 1'b0;
        bus.cfg_i = 24'h300001;
        nz = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.pwm_o !== 1'b0) nz++;
        end
        total++;
        if (nz !== 0) begin
            bad++;
            $display("FAIL disabled_low got high_samples=%0d want 0", nz);
        end
        bus.en_i = 1'b1;
        measure(2 * FULL, -1, 24'h0);
        total++;
        if (per_hi[0] !== 49) begin
            bad++;
            $display("FAIL reenable_p0 got high=%0d want 49", per_hi[0]);
        end
        total++;
        if (per_hi[1] !== 48) begin
            bad++;
            $display("FAIL reenable_p1 got high=%0d want 48", per_hi[1]);
        end
        total++;
        if (frm_cnt !== 0) begin
            bad++;
            $display("FAIL reenable_frame got count=%0d want 0", frm_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_half_duty();
        test_dither();
        test_saturation();
        test_setpoint();
        test_frame_edge();
        test_enable();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
